result_history: RTL and testbench
=================================

RESULT_HISTORY -- requirements
Module: result_history

Interface
REQ-001 Parameter WIDTH, default 16: data width of each stored result; legal range 1..32.
REQ-002 Parameter DEPTH, default 8: number of results retained; legal range 2..16; power of two not required.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion and active-low.
REQ-005 en  input  1  store request; push d as newest entry.
REQ-006 d  input  WIDTH  result to store.
REQ-007 undo  input  1  discard newest entry.
REQ-008 clr  input  1  synchronous clear of all history.
REQ-009 sel  input  $clog2(DEPTH)  recall index; 0 = newest, k = k-th older.
REQ-010 q  output  WIDTH  registered newest entry; 0 when empty.
REQ-011 recall  output  WIDTH  registered entry addressed by sel.
REQ-012 recall_vld  output  1  registered; 1 when sel < count at sampling edge.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
REQ-014 empty / full  output  1 each  count==0 / count==DEPTH, combinational from count.
REQ-015 ovf  output  1  one-cycle pulse: a store discarded the oldest entry.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x WIDTH with write pointer wp (next free slot) wrapping DEPTH-1 -> 0 explicitly, not by bit truncation.
REQ-017 Per-edge priority SHALL be: clr > (en && undo) > en > undo > hold.
REQ-018 clr: count -> 0, wp -> 0, q -> 0, ovf -> 0; storage contents need not be zeroed.
REQ-019 en alone, count < DEPTH: write d at wp, wp+1 (wrapped), count+1, q <= d on the same edge.
REQ-020 en alone, count == DEPTH: write d at wp (overwrites oldest), wp+1, count unchanged, ovf = 1 for that cycle only.
REQ-021 undo alone, count > 0: wp-1 (wrapped DEPTH-1 at 0), count-1, q <= entry now newest, or 0 if count becomes 0.
REQ-022 undo alone on empty SHALL be ignored: no state change, no error flag.
REQ-023 en && undo with count > 0: overwrite newest entry (slot wp-1) with d, wp and count unchanged, q <= d, ovf = 0.
REQ-024 en && undo with count == 0: behave as en alone.
REQ-025 Recall SHALL have latency 1: at each edge, recall <= entry at (wp-1-sel) mod DEPTH using pre-edge state, recall_vld <= (sel < count); when invalid, recall <= 0.
REQ-026 Recall of an entry being modified on the same edge SHALL return the pre-edge value.
REQ-027 ovf SHALL be 0 in every cycle not described by REQ-020.
REQ-028 No combinational path SHALL exist from any input to q, recall, recall_vld or ovf.

Reset
REQ-029 On rst_n low, asynchronously: count=0, wp=0, q=0, recall=0, recall_vld=0, ovf=0; empty=1, full=0.
REQ-030 Storage array SHALL NOT require reset; its contents are unobservable while count==0.
REQ-031 Reset asserted mid-sequence SHALL abandon any in-flight store/undo/recall; first edge after rst_n high SHALL act on that cycle's inputs normally.

Verification (WIDTH=16, DEPTH=4)
REQ-032 Reset, then en with d=0x0011,0x0022,0x0033 -> q=0x0033, count=3, empty=0, full=0, ovf never 1.
REQ-033 Fill with 0x0001..0x0004, then en d=0x0005 -> count=4, full=1, ovf pulses 1 cycle; sel=3 recall=0x0002, recall_vld=1.
REQ-034 From {0x0001,0x0002}, undo twice, then undo again -> q=0x0001, then q=0, count=0, empty=1; third undo leaves all outputs unchanged.
REQ-035 From {0x0001,0x0002}, en=1 undo=1 d=0x00FF -> q=0x00FF, count=2, sel=1 recall=0x0001; sel=2 -> recall_vld=0, recall=0.
REQ-036 From full, assert clr with en=1 and undo=1 -> count=0, q=0, ovf=0; next en d=0x0AAA -> q=0x0AAA, count=1.
REQ-037 Drive rst_n low between edges mid-fill -> outputs reach reset values before the next clk edge; wrap of wp across 6 stores/3 undos checked against a reference queue model.

Source files
------------

// File: rtl/result_history.sv
// Last-DEPTH results kept in a circular buffer, with undo of the newest entry
// and a registered one-cycle-latency recall port indexed from the newest entry.
module result_history #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int SW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             undo,
    input  logic             clr,
    input  logic [SW-1:0]    sel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] recall,
    output logic             recall_vld,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf
);
    localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SW-1:0]    wp, wp_inc, wp_dec, wp_dec2, waddr, sel_c;
    logic [SW:0]      ridx;
    logic             we, rvld_nxt, has;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign has   = !empty;

    always_comb begin
        wp_inc  = (wp == LAST) ? '0 : wp + 1'b1;
        wp_dec  = (wp == '0) ? LAST : wp - 1'b1;
        wp_dec2 = (wp_dec == '0) ? LAST : wp_dec - 1'b1;
        // Out-of-range sel is clamped only to keep the index inside the array;
        // its result is masked to 0 anyway.
        sel_c   = (32'(sel) < 32'(DEPTH)) ? sel : '0;
        ridx    = {1'b0, wp} + (SW+1)'(DEPTH - 1) - {1'b0, sel_c};
        if (ridx >= (SW+1)'(DEPTH))
            ridx = ridx - (SW+1)'(DEPTH);
        rvld_nxt = 32'(sel) < 32'(count);
    end

    always_comb begin
        we    = 1'b0;
        waddr = wp;
        if (!clr && en) begin
            we    = 1'b1;
            waddr = (undo && has) ? wp_dec : wp;
        end
    end

    // Storage carries no reset; nothing in it is visible while count is 0.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            count      <= '0;
            q          <= '0;
            recall     <= '0;
            recall_vld <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            ovf        <= 1'b0;
            // Recall always samples pre-edge state, so same-edge edits are not seen.
            recall_vld <= rvld_nxt;
            recall     <= rvld_nxt ? mem[ridx[SW-1:0]] : '0;
            if (clr) begin
                wp    <= '0;
                count <= '0;
                q     <= '0;
            end else if (en && undo && has) begin
                q <= d;
            end else if (en) begin
                wp <= wp_inc;
                q  <= d;
                if (full)
                    ovf <= 1'b1;
                else
                    count <= count + 1'b1;
            end else if (undo && has) begin
                wp    <= wp_dec;
                count <= count - 1'b1;
                q     <= (count == CW'(1)) ? '0 : mem[wp_dec2];
            end
        end
    end
endmodule

// File: tb/tb_result_history.sv
// Directed bench for result_history at WIDTH=16, DEPTH=4, with a queue
// reference model for the pointer-wrap sequence.
module tb_result_history;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en, undo, clr;
    logic [WIDTH-1:0]  d;
    logic [1:0]        sel;
    logic [WIDTH-1:0]  q, recall;
    logic              recall_vld, empty, full, ovf;
    logic [2:0]        count;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] mdl[$];

    result_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .undo(undo), .clr(clr),
        .sel(sel), .q(q), .recall(recall), .recall_vld(recall_vld),
        .count(count), .empty(empty), .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic u, input logic c, input logic [15:0] dv);
        en = e; undo = u; clr = c; d = dv;
        tick();
        en = 0; undo = 0; clr = 0;
    endtask

    task automatic push(input logic [15:0] dv);
        drive(1, 0, 0, dv);
    endtask

    // Drive one operation, advance the reference queue, compare.
    task automatic mop(input logic e, input logic u, input logic [15:0] dv);
        logic exp_ovf;
        exp_ovf = 0;
        if (e && u && mdl.size() > 0) mdl[0] = dv;
        else if (e) begin
            mdl.push_front(dv);
            if (mdl.size() > DEPTH) begin
                void'(mdl.pop_back());
                exp_ovf = 1;
            end
        end else if (u && mdl.size() > 0) void'(mdl.pop_front());
        drive(e, u, 0, dv);
        chk("m_q", 32'(q), (mdl.size() > 0) ? 32'(mdl[0]) : 0);
        chk("m_cnt", 32'(count), mdl.size());
        chk("m_ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        rst_n = 0; en = 0; undo = 0; clr = 0; d = '0; sel = '0;
        #2;
        chk("rst_q", 32'(q), 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_rvld", 32'(recall_vld), 0);
        chk("rst_recall", 32'(recall), 0);
        tick(); tick();
        rst_n = 1;

        // Basic fill
        push(16'h0011); chk("b_ovf0", 32'(ovf), 0);
        push(16'h0022); chk("b_ovf1", 32'(ovf), 0);
        push(16'h0033); chk("b_ovf2", 32'(ovf), 0);
        chk("b_q", 32'(q), 32'h33);
        chk("b_cnt", 32'(count), 3);
        chk("b_empty", 32'(empty), 0);
        chk("b_full", 32'(full), 0);

        // Overflow
        drive(0, 0, 1, '0);
        for (int i = 1; i <= 4; i++) begin
            push(16'(i));
            chk("o_ovf_fill", 32'(ovf), 0);
        end
        chk("o_full4", 32'(full), 1);
        push(16'h0005);
        chk("o_ovf", 32'(ovf), 1);
        chk("o_cnt", 32'(count), 4);
        chk("o_full", 32'(full), 1);
        sel = 2'd3;
        tick();
        chk("o_ovf_pulse", 32'(ovf), 0);
        chk("o_recall3", 32'(recall), 32'h2);
        chk("o_rvld3", 32'(recall_vld), 1);
        chk("o_q", 32'(q), 32'h5);
        sel = 2'd0;

        // Undo to empty and beyond
        drive(0, 0, 1, '0);
        push(16'h0001); push(16'h0002);
        drive(0, 1, 0, '0);
        chk("u_q1", 32'(q), 32'h1);
        chk("u_cnt1", 32'(count), 1);
        drive(0, 1, 0, '0);
        chk("u_q0", 32'(q), 0);
        chk("u_cnt0", 32'(count), 0);
        chk("u_empty", 32'(empty), 1);
        drive(0, 1, 0, '0);
        chk("u_q_idle", 32'(q), 0);
        chk("u_cnt_idle", 32'(count), 0);
        chk("u_empty_idle", 32'(empty), 1);
        chk("u_full_idle", 32'(full), 0);
        chk("u_ovf_idle", 32'(ovf), 0);

        // Replace newest; recall on the same edge sees the old value
        drive(0, 0, 1, '0);
        push(16'h0001); push(16'h0002);
        sel = 2'd0;
        drive(1, 1, 0, 16'h00FF);
        chk("r_q", 32'(q), 32'hFF);
        chk("r_cnt", 32'(count), 2);
        chk("r_recall_pre", 32'(recall), 32'h2);
        sel = 2'd1; tick();
        chk("r_recall1", 32'(recall), 32'h1);
        chk("r_rvld1", 32'(recall_vld), 1);
        sel = 2'd2; tick();
        chk("r_rvld2", 32'(recall_vld), 0);
        chk("r_recall2", 32'(recall), 0);
        sel = 2'd0; tick();
        chk("r_recall0", 32'(recall), 32'hFF);

        // Clear beats en+undo; en+undo on empty is a store
        for (int i = 1; i <= 4; i++) push(16'(i));
        drive(1, 1, 1, 16'h0077);
        chk("c_cnt", 32'(count), 0);
        chk("c_q", 32'(q), 0);
        chk("c_ovf", 32'(ovf), 0);
        chk("c_empty", 32'(empty), 1);
        push(16'h0AAA);
        chk("c_q2", 32'(q), 32'hAAA);
        chk("c_cnt2", 32'(count), 1);
        drive(0, 0, 1, '0);
        drive(1, 1, 0, 16'h0055);
        chk("e_q", 32'(q), 32'h55);
        chk("e_cnt", 32'(count), 1);

        // Asynchronous reset between edges
        push(16'h0066); push(16'h0067);
        #2 rst_n = 0;
        #1;
        chk("a_q", 32'(q), 0);
        chk("a_cnt", 32'(count), 0);
        chk("a_empty", 32'(empty), 1);
        chk("a_rvld", 32'(recall_vld), 0);
        chk("a_recall", 32'(recall), 0);
        #1 rst_n = 1;
        push(16'h0088);
        chk("a_q_after", 32'(q), 32'h88);
        chk("a_cnt_after", 32'(count), 1);

        // Pointer wrap against the reference queue
        drive(0, 0, 1, '0);
        mdl.delete();
        for (int i = 1; i <= 6; i++) mop(1, 0, 16'(16'h0100 + i));
        for (int i = 0; i < 3; i++) mop(0, 1, '0);
        mop(1, 1, 16'h01AA);
        mop(1, 0, 16'h01BB);
        mop(1, 0, 16'h01CC);
        for (int s = 0; s < DEPTH; s++) begin
            sel = 2'(s);
            tick();
            chk("m_rvld", 32'(recall_vld), 32'(s < mdl.size()));
            chk("m_recall", 32'(recall), (s < mdl.size()) ? 32'(mdl[s]) : 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
